// File: rtl/des_pkg.sv
// Constant tables, state type and bit-permutation helpers for the DES decryption core.
// Tables use DES 1-based numbering where DES bit 1 is the vector MSB.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: entry index = {row, column}.
  localparam int unsigned SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,  0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,  15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,  3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,  13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,  1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,  13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,  3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,  14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,  11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,  10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,  13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,  1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = k[6'(64 - PC1_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = cd[6'(56 - PC2_T[j])];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic by_two);
    return by_two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R, K): expansion, key mix, S-box substitution, P permutation.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] e_s;
  logic [47:0] x_s;
  logic [31:0] s_s;
  logic [5:0]  six_s;

  always_comb begin
    e_s   = '0;
    s_s   = '0;
    six_s = '0;
    f_o   = '0;
    for (int j = 0; j < 48; j++) e_s[6'(47 - j)] = r_i[5'(32 - E_T[j])];
    x_s = e_s ^ k_i;
    // Row comes from the outer bits of each 6-bit group, column from the inner four.
    for (int k = 0; k < 8; k++) begin
      six_s = x_s[6'(42 - 6 * k) +: 6];
      s_s[5'(28 - 4 * k) +: 4] = 4'(SBOX[3'(k)][{six_s[5], six_s[0], six_s[4:1]}]);
    end
    for (int j = 0; j < 32; j++) f_o[5'(31 - j)] = s_s[5'(32 - P_T[j])];
  end

endmodule

// File: rtl/final_permutation.sv
// DES final permutation (inverse IP), purely combinational.
module final_permutation
  import des_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int j = 0; j < 64; j++) data_o[6'(63 - j)] = data_i[6'(64 - FP_T[j])];
  end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1 derived
// on the fly by rotating the PC-1 halves right.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pt_q, pt_d;
  logic        ov_q, ov_d;

  logic [47:0] subkey_s;
  logic [31:0] f_s, r_new_s;
  logic [63:0] ip_s, fp_s;
  logic [55:0] pc1_s;
  logic        shift2_s;

  assign ip_s     = ip_perm(ciphertext);
  assign pc1_s    = pc1_perm(key);
  assign subkey_s = pc2_perm({c_q, d_q});
  assign r_new_s  = l_q ^ f_s;
  // Reverse schedule: after round i undo the encryption shift SHIFT[15-i].
  assign shift2_s = (SHIFT[~cnt_q] == 32'd2);

  des_feistel_f u_feistel (
    .r_i (r_q),
    .k_i (subkey_s),
    .f_o (f_s)
  );

  // Last round's halves go out swapped (R16 || L16).
  final_permutation u_fp (
    .data_i ({r_new_s, r_q}),
    .data_o (fp_s)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = ip_s[63:32];
          r_d     = ip_s[31:0];
          c_d     = pc1_s[55:28];
          d_d     = pc1_s[27:0];
          cnt_d   = 4'd0;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = r_new_s;
        c_d = rotr28(c_q, shift2_s);
        d_d = rotr28(d_q, shift2_s);
        if (cnt_q == 4'd15) begin
          pt_d    = fp_s;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end else begin
          ov_d = 1'b1;
        end
      end
      default: begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign plaintext = pt_q;

endmodule
